// File: rtl/det_pkg.sv
// Shared definitions for the tridiagonal determinant engine and its loader.
// Word/coefficient widths and the SRAM map are common to both blocks.
package det_pkg;

  localparam int DET_WORD_W      = 32;
  localparam int DET_COEFF_W     = 16;
  localparam int DET_RESULT_ADDR = 14;
  localparam int DET_SRAM_ADDR_W = 7;
  localparam int DET_NUM_COEFF   = 28;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    RUN,
    RDRES,
    DONE,
    VERIFY
  } det_state_t;

  // Number of 32-bit words needed for n 16-bit coefficients.
  function automatic int det_words(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/det_coeff_packer.sv
// Packs a stream of 16-bit coefficients two per 32-bit SRAM word, high half
// first, and issues one write per completed word. An odd final coefficient is
// written immediately with a zero low half. o_last marks the final word write.
module det_coeff_packer
  import det_pkg::*;
#(
  parameter int NUM_COEFF = DET_NUM_COEFF,
  parameter int ADDR_W    = DET_SRAM_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_beat_valid,
  input  logic [DET_COEFF_W-1:0] i_beat_data,
  output logic                   o_we,
  output logic [ADDR_W-1:0]      o_addr,
  output logic [DET_WORD_W-1:0]  o_word,
  output logic                   o_last
);

  localparam logic [ADDR_W:0] LAST_BEAT = (ADDR_W + 1)'(NUM_COEFF - 1);

  logic                   r_half;
  logic [ADDR_W-1:0]      r_word_idx;
  logic [DET_COEFF_W-1:0] r_hi;
  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [DET_WORD_W-1:0]  r_word;
  logic                   r_last;
  logic                   w_final_beat;

  assign w_final_beat = ({r_word_idx, r_half} == LAST_BEAT);

  // Capture beats, emit a write the cycle after each word (or the odd tail) completes.
  always_ff @(posedge clock) begin
    // NOTE: synchronous reset inside the clocked block, and only non-blocking
    // assignments here so every register samples pre-edge values.
    if (!reset) begin
      r_half     <= 1'b0;
      r_word_idx <= '0;
      r_hi       <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_word     <= '0;
      r_last     <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_last <= 1'b0;
      if (i_beat_valid) begin
        if (!r_half && !w_final_beat) begin
          r_hi   <= i_beat_data;
          r_half <= 1'b1;
        end else begin
          r_we       <= 1'b1;
          r_addr     <= r_word_idx;
          r_word     <= r_half ? {r_hi, i_beat_data} : {i_beat_data, {DET_COEFF_W{1'b0}}};
          r_last     <= w_final_beat;
          r_half     <= 1'b0;
          r_word_idx <= w_final_beat ? '0 : r_word_idx + ADDR_W'(1);
        end
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_word = r_word;
  assign o_last = r_last;

endmodule

// File: rtl/det_matrix_loader.sv
// Feeder for the tridiagonal determinant engine: loads packed coefficients into
// the shared SRAM, starts the engine, waits for it and returns the result word.
// Optional macro LOADER_VERIFY_EN adds a read-back XOR check before the start.
module det_matrix_loader
  import det_pkg::*;
#(
  parameter int NUM_COEFF   = DET_NUM_COEFF,
  parameter int RESULT_ADDR = DET_RESULT_ADDR,
  parameter int ADDR_W      = DET_SRAM_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DET_COEFF_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   sram_own,
  output logic [ADDR_W-1:0]      writeAddress,
  output logic [DET_WORD_W-1:0]  writebus,
  output logic                   WE,
  output logic [ADDR_W-1:0]      readAddress,
  input  logic [DET_WORD_W-1:0]  readbus,
  output logic                   det_go,
  input  logic                   det_finished,
  output logic [DET_WORD_W-1:0]  result,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic                   busy,
  output logic                   error
);

  localparam int WORDS = det_words(NUM_COEFF);

  det_state_t            r_state;
  det_state_t            w_next;
  logic                  w_in_ready;
  logic                  w_own;
  logic                  w_go;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic                  w_take;
  logic                  w_pk_we;
  logic                  w_pk_last;
  logic [DET_WORD_W-1:0] w_pk_word;
  logic                  r_rd_phase;
  logic [DET_WORD_W-1:0] r_result;

  assign w_take = in_valid & in_ready;

  det_coeff_packer #(
    .NUM_COEFF(NUM_COEFF),
    .ADDR_W   (ADDR_W)
  ) u_packer (
    .clock       (clock),
    .reset       (reset),
    .i_beat_valid(w_take),
    .i_beat_data (in_data),
    .o_we        (w_pk_we),
    .o_addr      (writeAddress),
    .o_word      (w_pk_word),
    .o_last      (w_pk_last)
  );

`ifdef LOADER_VERIFY_EN
  logic [DET_WORD_W-1:0] r_csum;
  logic [DET_WORD_W-1:0] r_vxor;
  logic [ADDR_W:0]       r_vcnt;
  logic                  r_error;
  logic                  w_vdone;
  logic                  w_vfail;

  assign w_vdone = (r_state == VERIFY) && (r_vcnt == (ADDR_W + 1)'(WORDS));
  assign w_vfail = w_vdone && ((r_vxor ^ readbus) != r_csum);

  // Checksum of written words, read-back XOR and sticky mismatch flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_csum  <= '0;
      r_vxor  <= '0;
      r_vcnt  <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == IDLE)
        r_csum <= '0;
      else if (w_pk_we)
        r_csum <= r_csum ^ w_pk_word;
      if (r_state == VERIFY) begin
        r_vcnt <= r_vcnt + (ADDR_W + 1)'(1);
        if (r_vcnt != '0)
          r_vxor <= r_vxor ^ readbus;
      end else begin
        r_vcnt <= '0;
        r_vxor <= '0;
      end
      if (w_vfail)
        r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_own      = 1'b0;
    w_go       = 1'b0;
    w_rd_addr  = '0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_own      = 1'b1;
        if (in_valid)
          w_next = LOAD;
      end
      LOAD: begin
        w_own      = 1'b1;
        w_in_ready = !w_pk_last;
        if (w_pk_last)
`ifdef LOADER_VERIFY_EN
          w_next = VERIFY;
`else
          w_next = KICK;
`endif
      end
      KICK: begin
        w_go   = 1'b1;
        w_next = RUN;
      end
      RUN: begin
        if (det_finished)
          w_next = RDRES;
      end
      RDRES: begin
        w_own     = 1'b1;
        w_rd_addr = ADDR_W'(RESULT_ADDR);
        if (r_rd_phase)
          w_next = DONE;
      end
      DONE: begin
        if (result_ack)
          w_next = IDLE;
      end
`ifdef LOADER_VERIFY_EN
      VERIFY: begin
        w_own     = 1'b1;
        w_rd_addr = r_vcnt[ADDR_W-1:0];
        if (w_vdone)
          w_next = w_vfail ? IDLE : KICK;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // Result read: address issued in the first RDRES cycle, data captured in the second.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_phase <= 1'b0;
      r_result   <= '0;
    end else begin
      r_rd_phase <= (r_state == RDRES) && !r_rd_phase;
      if ((r_state == RDRES) && r_rd_phase)
        r_result <= readbus;
    end
  end

  assign in_ready     = reset & w_in_ready;
  assign sram_own     = reset & w_own;
  assign det_go       = reset & w_go;
  assign busy         = reset & (r_state != IDLE);
  assign readAddress  = w_rd_addr;
  assign WE           = w_pk_we;
  assign writebus     = w_pk_word;
  assign result       = r_result;
  assign result_valid = (r_state == DONE);

endmodule

// File: tb/tb_det_matrix_loader.sv
// Directed bench for det_matrix_loader: a 4-coefficient instance runs the full
// load/kick/run/read flow from a vector table, a 3-coefficient instance covers
// the odd-length tail, plus reset-abort and (with LOADER_VERIFY_EN) corruption.
module tb_det_matrix_loader;
  import det_pkg::*;

  localparam int AW = DET_SRAM_ADDR_W;
`ifdef LOADER_VERIFY_EN
  localparam int GO_DLY = 4;  // 2 read addresses + 1 compare cycle + KICK
`else
  localparam int GO_DLY = 1;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  // ---------------- 4-coefficient instance ----------------
  logic          rst4, iv4, ack4, fin4;
  logic [15:0]   id4;
  logic [31:0]   rb4;
  logic          ir4, own4, we4, go4, rv4, busy4, err4;
  logic [AW-1:0] wa4, ra4;
  logic [31:0]   wb4, res4;

  det_matrix_loader #(.NUM_COEFF(4)) u_dut4 (
    .clock(clock), .reset(rst4), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .sram_own(own4), .writeAddress(wa4), .writebus(wb4), .WE(we4),
    .readAddress(ra4), .readbus(rb4), .det_go(go4), .det_finished(fin4),
    .result(res4), .result_valid(rv4), .result_ack(ack4), .busy(busy4), .error(err4)
  );

  logic [31:0] mem4 [0:127];
  logic        eng_we, corrupt;
  logic [31:0] eng_val;

  always @(posedge clock) begin
    if (we4 && own4)
      mem4[wa4] <= (corrupt && wa4 == 7'd1) ? (wb4 ^ 32'h0000_0100) : wb4;
    if (eng_we)
      mem4[DET_RESULT_ADDR] <= eng_val;
    rb4 <= mem4[ra4];
  end

  wr_t wq4[$];
  int  cyc = 0, last_we_cyc = 0, go_cyc = 0, go_cnt4 = 0, own_viol = 0;
  bit  saw_rd14;

  always @(negedge clock) begin
    cyc++;
    if (we4) begin
      wq4.push_back('{a: wa4, d: wb4});
      last_we_cyc = cyc;
      if (!own4) own_viol++;
    end
    if (go4) begin
      go_cnt4++;
      go_cyc = cyc;
    end
    if (ra4 == 7'd14 && own4 && busy4) saw_rd14 = 1'b1;
  end

  // ---------------- 3-coefficient instance ----------------
  logic          rst3, iv3;
  logic [15:0]   id3;
  logic [31:0]   rb3;
  logic          ir3, own3, we3, go3, rv3, busy3, err3;
  logic [AW-1:0] wa3, ra3;
  logic [31:0]   wb3, res3;
  logic          fin3 = 1'b0, ack3 = 1'b0;

  det_matrix_loader #(.NUM_COEFF(3)) u_dut3 (
    .clock(clock), .reset(rst3), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .sram_own(own3), .writeAddress(wa3), .writebus(wb3), .WE(we3),
    .readAddress(ra3), .readbus(rb3), .det_go(go3), .det_finished(fin3),
    .result(res3), .result_valid(rv3), .result_ack(ack3), .busy(busy3), .error(err3)
  );

  logic [31:0] mem3 [0:127];
  always @(posedge clock) begin
    if (we3 && own3) mem3[wa3] <= wb3;
    rb3 <= mem3[ra3];
  end

  wr_t wq3[$];
  int  go_cnt3 = 0;
  always @(negedge clock) begin
    if (we3) wq3.push_back('{a: wa3, d: wb3});
    if (go3) go_cnt3++;
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [63:0] beats;  // beat 0 in [63:48]
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] res;
    logic        early_fin;
  } vec_t;

  vec_t vecs [3];

  task automatic load4(input logic [63:0] beats);
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      iv4 = 1'b1;
      id4 = beats[63 - 16*b -: 16];
      check($sformatf("in_ready_beat%0d", b), ir4, 1'b1);
    end
    @(negedge clock);
    iv4 = 1'b0;
  endtask

  task automatic wait_go4(output bit ok);
    int t = 0;
    while (go4 !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    ok = (go4 === 1'b1);
  endtask

  task automatic run_matrix(input int r);
    bit ok;
    int t, bad, go_before;
    logic [31:0] exp_res;
    exp_res   = vecs[r].res;
    wq4.delete();
    saw_rd14  = 1'b0;
    go_before = go_cnt4;
    load4(vecs[r].beats);
    wait_go4(ok);
    check($sformatf("r%0d_det_go_seen", r), ok, 1'b1);
    check($sformatf("r%0d_kick_own", r), own4, 1'b0);
    if (vecs[r].early_fin) begin
      fin4 = 1'b1; eng_we = 1'b1; eng_val = exp_res;
      @(negedge clock);
      eng_we = 1'b0;
      check($sformatf("r%0d_no_early_exit", r), {own4, busy4}, 2'b01);
      @(negedge clock);
      check($sformatf("r%0d_rdres_own", r), own4, 1'b1);
    end else begin
      bad = 0;
      repeat (3) begin
        @(negedge clock);
        if (own4 !== 1'b0 || busy4 !== 1'b1) bad++;
      end
      check($sformatf("r%0d_run_own_low", r), bad, 0);
      fin4 = 1'b1; eng_we = 1'b1; eng_val = exp_res;
      @(negedge clock);
      fin4 = 1'b0; eng_we = 1'b0;
    end
    t = 0;
    while (rv4 !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    fin4 = 1'b0;
    check($sformatf("r%0d_result_valid", r), rv4, 1'b1);
    check($sformatf("r%0d_result", r), res4, exp_res);
    check($sformatf("r%0d_read_addr14", r), saw_rd14, 1'b1);
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (rv4 !== 1'b1 || res4 !== exp_res) bad++;
    end
    check($sformatf("r%0d_result_hold", r), bad, 0);
    ack4 = 1'b1; iv4 = 1'b1; id4 = 16'h5555;
    check($sformatf("r%0d_ack_wins_in_ready", r), ir4, 1'b0);
    @(negedge clock);
    ack4 = 1'b0; iv4 = 1'b0;
    check($sformatf("r%0d_after_ack", r), {rv4, busy4}, 2'b00);
    repeat (2) @(negedge clock);
    check($sformatf("r%0d_write_count", r), wq4.size(), 2);
    if (wq4.size() >= 2) begin
      check($sformatf("r%0d_word0", r), {wq4[0].a, wq4[0].d}, {7'd0, vecs[r].w0});
      check($sformatf("r%0d_word1", r), {wq4[1].a, wq4[1].d}, {7'd1, vecs[r].w1});
    end
    check($sformatf("r%0d_go_pulses", r), go_cnt4 - go_before, 1);
    check($sformatf("r%0d_go_delay", r), go_cyc - last_we_cyc, GO_DLY);
    check($sformatf("r%0d_error", r), err4, 1'b0);
  endtask

  initial begin
    bit ok;
    int t, go_before, wq_before;

    vecs[0] = '{64'h0001_0002_FFFF_8000, 32'h0001_0002, 32'hFFFF_8000, 32'hFFFF_FFF3, 1'b0};
    vecs[1] = '{64'h1234_5678_9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0007, 1'b0};
    vecs[2] = '{64'h8000_7FFF_0000_FFFF, 32'h8000_7FFF, 32'h0000_FFFF, 32'h8000_0000, 1'b1};

    rst4 = 1'b0; iv4 = 1'b0; id4 = '0; ack4 = 1'b0; fin4 = 1'b0;
    eng_we = 1'b0; eng_val = '0; corrupt = 1'b0;
    rst3 = 1'b0; iv3 = 1'b0; id3 = '0;

    repeat (3) @(negedge clock);
    check("reset_outputs", {busy4, ir4, own4, we4, go4, rv4, err4}, 7'b0);
    check("reset_buses", {wa4, ra4, wb4, res4}, 78'b0);
    rst4 = 1'b1; rst3 = 1'b1;
    @(negedge clock);
    check("idle_ready_own_busy", {ir4, own4, busy4}, 3'b110);

    // Odd coefficient count with in_valid gaps.
    @(negedge clock); iv3 = 1'b1; id3 = 16'd5;
    @(negedge clock); iv3 = 1'b0;
    @(negedge clock);
    check("gap_in_ready", ir3, 1'b1);
    @(negedge clock);
    check("gap_no_write", wq3.size(), 0);
    iv3 = 1'b1; id3 = 16'd6;
    @(negedge clock); iv3 = 1'b0;
    @(negedge clock);
    check("gap2_in_ready", ir3, 1'b1);
    iv3 = 1'b1; id3 = 16'd7;
    @(negedge clock); iv3 = 1'b0;
    t = 0;
    while (go3 !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("odd_det_go_seen", go3, 1'b1);
    check("odd_kick_own", own3, 1'b0);
    repeat (2) @(negedge clock);
    check("odd_write_count", wq3.size(), 2);
    if (wq3.size() >= 2) begin
      check("odd_word0", {wq3[0].a, wq3[0].d}, {7'd0, 32'h0005_0006});
      check("odd_word1", {wq3[1].a, wq3[1].d}, {7'd1, 32'h0007_0000});
    end
    check("odd_go_pulses", go_cnt3, 1);
    check("odd_waiting_run", {busy3, own3, rv3, err3}, 4'b1000);

    // Table-driven full flows.
    for (int r = 0; r < 3; r++) run_matrix(r);

    // Reset during RUN aborts immediately.
    load4(vecs[0].beats);
    wait_go4(ok);
    check("abort_det_go_seen", ok, 1'b1);
    @(negedge clock);
    check("abort_in_run", {busy4, own4}, 2'b10);
    rst4 = 1'b0;
    @(negedge clock);
    check("abort_outputs", {busy4, ir4, own4, we4, go4, rv4, err4}, 7'b0);
    check("abort_buses", {wa4, ra4, wb4, res4}, 78'b0);
    @(negedge clock);
    rst4 = 1'b1;
    go_before = go_cnt4;
    wq_before = wq4.size();
    repeat (12) @(negedge clock);
    check("abort_no_go", go_cnt4 - go_before, 0);
    check("abort_no_we", wq4.size() - wq_before, 0);
    check("abort_idle", {busy4, ir4}, 2'b01);

`ifdef LOADER_VERIFY_EN
    // Corrupted read-back: error, no start, back to IDLE.
    corrupt   = 1'b1;
    go_before = go_cnt4;
    wq4.delete();
    load4(vecs[1].beats);
    t = 0;
    while (busy4 !== 1'b0 && t < 40) begin
      @(negedge clock);
      t++;
    end
    check("verify_back_idle", busy4, 1'b0);
    check("verify_error", err4, 1'b1);
    check("verify_no_go", go_cnt4 - go_before, 0);
    check("verify_writes", wq4.size(), 2);
    corrupt = 1'b0;
    repeat (3) @(negedge clock);
    check("verify_error_sticky", err4, 1'b1);
    rst4 = 1'b0;
    @(negedge clock);
    rst4 = 1'b1;
    @(negedge clock);
    check("verify_error_cleared", err4, 1'b0);
`endif

    check("we_only_when_owned", own_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
